// File: rtl/ssd_scan_driver.sv
// ============================================================================
// Module      : ssd_scan_driver
// Description : Four-digit, common-anode, multiplexed seven-segment driver.
//               The 13-bit binary input is converted to BCD by a sequential
//               double-dabble engine (one shift per clock). The result is
//               scanned across the digits at a divided refresh rate, with
//               optional leading-zero blanking.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous, active-low reset
//               num   - unsigned value to display, 0..8191
//               anode - digit enables, active-low, bit0 = units
//               seg   - segments {g,f,e,d,c,b,a}, active-low
//               busy  - high while a conversion is in progress
//               bcd   - displayed digits {thousands,hundreds,tens,units}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_driver #(
  parameter int SCAN_BITS = 18,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy,
  output logic [15:0] bcd
);

  localparam logic [3:0] NUM_SHIFTS = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           capture;
  logic           do_shift;
  logic           do_load;

  logic [12:0]    last_num;
  logic [12:0]    bin;
  logic [15:0]    bcd_work;
  logic [15:0]    bcd_adj;
  logic [3:0]     count;

  logic [SCAN_BITS-1:0] refresh;
  logic [1:0]     sel;
  logic [3:0]     digit;
  logic           blank;
  logic [6:0]     seg_nxt;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    do_shift  = 1'b0;
    do_load   = 1'b0;
    case (state)
      IDLE: begin
        // Comparing against the last captured value lets a change made
        // during a conversion start a fresh one once this one finishes.
        if (num != last_num) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (count == 4'd1) state_nxt = LOAD;
      end
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every working nibble before each shift.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[i*4 +: 4] = (bcd_work[i*4 +: 4] >= 4'd5) ?
                               bcd_work[i*4 +: 4] + 4'd3 :
                               bcd_work[i*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_num <= '0;
      bin      <= '0;
      bcd_work <= '0;
      count    <= '0;
      bcd      <= '0;
      busy     <= 1'b0;
    end else begin
      if (capture) begin
        last_num <= num;
        bin      <= num;
        bcd_work <= '0;
        count    <= NUM_SHIFTS;
        busy     <= 1'b1;
      end
      if (do_shift) begin
        {bcd_work, bin} <= {bcd_adj[14:0], bin, 1'b0};
        count           <= count - 4'd1;
      end
      // Only the finished result reaches bcd; the display never sees the
      // working register.
      if (do_load) begin
        bcd  <= bcd_work;
        busy <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit scanning
  // --------------------------------------------------------------------------
  assign sel = refresh[SCAN_BITS-1 -: 2];

  always_comb begin
    digit = bcd[3:0];
    case (sel)
      2'd0: digit = bcd[3:0];
      2'd1: digit = bcd[7:4];
      2'd2: digit = bcd[11:8];
      2'd3: digit = bcd[15:12];
      default: digit = bcd[3:0];
    endcase
  end

  if (BLANK_LZ) begin : g_blank
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
      blank = 1'b0;
      case (sel)
        2'd1: blank = (bcd[15:4] == 12'd0);
        2'd2: blank = (bcd[15:8] == 8'd0);
        2'd3: blank = (bcd[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end else begin : g_no_blank
    assign blank = 1'b0;
  end

  always_comb begin
    seg_nxt = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0: seg_nxt = 7'b1000000;
        4'd1: seg_nxt = 7'b1111001;
        4'd2: seg_nxt = 7'b0100100;
        4'd3: seg_nxt = 7'b0110000;
        4'd4: seg_nxt = 7'b0011001;
        4'd5: seg_nxt = 7'b0010010;
        4'd6: seg_nxt = 7'b0000010;
        4'd7: seg_nxt = 7'b1111000;
        4'd8: seg_nxt = 7'b0000000;
        4'd9: seg_nxt = 7'b0010000;
        default: seg_nxt = 7'b1111111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
      anode   <= 4'b1111;
      seg     <= 7'b1111111;
    end else begin
      refresh <= refresh + 1'b1;
      anode   <= ~(4'b0001 << sel);
      seg     <= seg_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// ============================================================================
// Module      : tb_ssd_scan_driver
// Description : Self-checking bench for ssd_scan_driver. Two instances share
//               the inputs, one with leading-zero blanking and one without.
//               Expected digits, segments and anodes come from decimal
//               arithmetic on the applied value and an edge count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] num = 13'd0;
  logic [3:0]  anode0, anode1;
  logic [6:0]  seg0, seg1;
  logic        busy0, busy1;
  logic [15:0] bcd0, bcd1;

  int passed = 0;
  int total  = 0;
  int edges  = 0;

  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};
  int pow10 [0:3] = '{1, 10, 100, 1000};

  ssd_scan_driver #(.SCAN_BITS(4), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .num(num),
    .anode(anode0), .seg(seg0), .busy(busy0), .bcd(bcd0));

  ssd_scan_driver #(.SCAN_BITS(4), .BLANK_LZ(1'b0)) dut_lit (
    .clk(clk), .rst(rst), .num(num),
    .anode(anode1), .seg(seg1), .busy(busy1), .bcd(bcd1));

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Caller has already presented the value (or released reset) at a negedge.
  task automatic run_conv(input int v, input logic [15:0] old_bcd, input string tag);
    int first = 0;
    int bcnt  = 0;
    logic [15:0] at_change = '0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (first == 0 && bcd0 !== old_bcd) begin
        first     = e;
        at_change = bcd0;
      end
    end
    chk({tag, "_latency"}, first, 15);
    chk({tag, "_first_value"}, at_change, to_bcd(v));
    chk({tag, "_bcd"}, bcd0, to_bcd(v));
    chk({tag, "_bcd_lit"}, bcd1, to_bcd(v));
    chk({tag, "_busy_cycles"}, bcnt, 14);
  endtask

  // Sixteen scan cycles checked against the value currently on display.
  task automatic disp_check(input int v, input string tag);
    for (int c = 0; c < 16; c++) begin
      int s;
      int dig;
      logic [3:0] ea;
      logic [6:0] es;
      @(negedge clk);
      s   = ((edges - 1) % 16) / 4;
      dig = (v / pow10[s]) % 10;
      ea  = ~(4'b0001 << s);
      es  = (s > 0 && v < pow10[s]) ? 7'b1111111 : segtab[dig];
      chk({tag, "_anode"}, anode0, ea);
      chk({tag, "_seg"}, seg0, es);
      chk({tag, "_anode_lit"}, anode1, ea);
      chk({tag, "_seg_lit"}, seg1, segtab[dig]);
    end
  endtask

  initial begin
    int v;
    int prev;
    int f100;
    int f9;
    int bad;

    // Reset held with a nonzero input.
    num = 13'd1234;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode", anode0, 4'b1111);
    chk("rst_seg", seg0, 7'b1111111);
    chk("rst_bcd", bcd0, 16'h0000);
    chk("rst_busy", busy0, 1'b0);
    rst = 1'b1;
    #1;
    chk("release_busy", busy0, 1'b0);
    run_conv(1234, 16'h0000, "first");
    disp_check(1234, "disp1234");

    // Maximum value.
    @(negedge clk);
    num = 13'd8191;
    run_conv(8191, to_bcd(1234), "max");
    disp_check(8191, "disp8191");

    // Leading-zero blanking.
    @(negedge clk);
    num = 13'd7;
    run_conv(7, to_bcd(8191), "seven");
    disp_check(7, "disp7");
    prev = 7;

    // Random values.
    for (int r = 0; r < 5; r++) begin
      do v = int'($urandom_range(0, 8191)); while (v == prev || v == 100 || v == 9);
      @(negedge clk);
      num = 13'(v);
      run_conv(v, to_bcd(prev), "rand");
      disp_check(v, "disp_rand");
      prev = v;
    end

    // Input changes while converting: only the final value may follow 100.
    @(negedge clk);
    num  = 13'd100;
    f100 = 0;
    f9   = 0;
    bad  = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (bcd0 !== to_bcd(prev) && bcd0 !== 16'h0100 && bcd0 !== 16'h0009) bad++;
      if (f100 == 0 && bcd0 === 16'h0100) f100 = e;
      if (f9 == 0 && bcd0 === 16'h0009) f9 = e;
      if (e == 5) num = 13'd42;
      if (e == 6) num = 13'd9;
    end
    chk("chg_no_intermediate", bad, 0);
    chk("chg_first_latency", f100, 15);
    chk("chg_final_latency", f9, 30);
    chk("chg_final_bcd", bcd0, 16'h0009);

    // Reset in the middle of a conversion.
    @(negedge clk);
    num = 13'd5000;
    repeat (7) @(negedge clk);
    chk("mid_busy_before", busy0, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_bcd", bcd0, 16'h0000);
    chk("mid_busy", busy0, 1'b0);
    chk("mid_anode", anode0, 4'b1111);
    chk("mid_seg", seg0, 7'b1111111);
    @(negedge clk);
    rst = 1'b1;
    run_conv(5000, 16'h0000, "after_rst");
    disp_check(5000, "disp5000");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Overall guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
